// File: rtl/riscv_core_mul_seq.sv
// riscv_core_mul_seq: iterative radix-2^RADIX_BITS multiplier for the RV64 M
// extension (MUL, MULH, MULHSU, MULHU, MULW) with a valid/ready handshake.
//
// Optional feature: define MUL_ZERO_BYPASS_EN to finish zero-operand
// operations immediately (IDLE -> DONE, result 0).
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_mul_valid/o_mul_ready operation handshake (ready only in IDLE)
//   i_mul_srcA/i_mul_srcB   rs1/rs2 operands
//   i_mul_control           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_mul_isword            MULW, overrides i_mul_control
//   i_mul_tag               destination tag carried with the operation
//   i_mul_flush             abort any operation in flight
//   o_mul_valid/i_mul_res_ready  result handshake
//   o_mul_result/o_mul_tag  result and its tag, stable while o_mul_valid
module riscv_core_mul_seq #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned RADIX_BITS = 2,
   parameter int unsigned TAG_W      = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_mul_valid,
   output logic             o_mul_ready,
   input  logic [XLEN-1:0]  i_mul_srcA,
   input  logic [XLEN-1:0]  i_mul_srcB,
   input  logic [1:0]       i_mul_control,
   input  logic             i_mul_isword,
   input  logic [TAG_W-1:0] i_mul_tag,
   input  logic             i_mul_flush,
   output logic             o_mul_valid,
   input  logic             i_mul_res_ready,
   output logic [XLEN-1:0]  o_mul_result,
   output logic [TAG_W-1:0] o_mul_tag
);

   localparam int unsigned HALF   = XLEN / 2;
   localparam int unsigned PW     = 2 * XLEN;
   localparam int unsigned N_FULL = XLEN / RADIX_BITS;
   localparam int unsigned N_WORD = HALF / RADIX_BITS;
   localparam int unsigned CNT_W  = (N_FULL > 1) ? $clog2(N_FULL) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_SIGN,
      ST_DONE
   } state_t;

   state_t             state_q, state_nxt;
   logic [PW-1:0]      acc_q;
   logic [PW-1:0]      mcand_q;
   logic [XLEN-1:0]    mplier_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_q;
   logic [1:0]         ctrl_q;
   logic               word_q;
   logic [TAG_W-1:0]   tag_q;

   logic               accept_c;
   logic               sign_a_c, sign_b_c, zero_c;
   logic [XLEN-1:0]    val_a_c, val_b_c, mag_a_c, mag_b_c;
   logic [CNT_W-1:0]   last_c;
   logic [PW-1:0]      addend_c, prod_c;
   logic [XLEN-1:0]    res_sel_c;

   assign accept_c = i_mul_valid & o_mul_ready & ~i_mul_flush;

   // Operand conditioning: signedness per op, then magnitude form.
   always_comb begin
      sign_a_c = 1'b0;
      sign_b_c = 1'b0;
      val_a_c  = i_mul_srcA;
      val_b_c  = i_mul_srcB;
      if (i_mul_isword) begin
         val_a_c  = {{HALF{i_mul_srcA[HALF-1]}}, i_mul_srcA[HALF-1:0]};
         val_b_c  = {{HALF{i_mul_srcB[HALF-1]}}, i_mul_srcB[HALF-1:0]};
         sign_a_c = i_mul_srcA[HALF-1];
         sign_b_c = i_mul_srcB[HALF-1];
      end else begin
         sign_a_c = (i_mul_control != 2'b11) & i_mul_srcA[XLEN-1];
         sign_b_c = ~i_mul_control[1] & i_mul_srcB[XLEN-1];
      end
      mag_a_c = sign_a_c ? (~val_a_c + XLEN'(1)) : val_a_c;
      mag_b_c = sign_b_c ? (~val_b_c + XLEN'(1)) : val_b_c;
      zero_c  = (mag_a_c == '0) | (mag_b_c == '0);
   end

   // One radix digit of the multiplier times the (pre-shifted) multiplicand.
   always_comb begin
      addend_c = '0;
      for (int unsigned i = 0; i < RADIX_BITS; i++) begin
         if (mplier_q[i]) addend_c = addend_c + (mcand_q << i);
      end
   end

   // Sign correction and architectural result selection.
   always_comb begin
      prod_c = neg_q ? (~acc_q + PW'(1)) : acc_q;
      if (word_q)               res_sel_c = {{HALF{prod_c[HALF-1]}}, prod_c[HALF-1:0]};
      else if (ctrl_q == 2'b00) res_sel_c = prod_c[XLEN-1:0];
      else                      res_sel_c = prod_c[PW-1:XLEN];
   end

   assign last_c = word_q ? CNT_W'(N_WORD - 1) : CNT_W'(N_FULL - 1);

   // Next-state logic; flush overrides everything.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
`ifdef MUL_ZERO_BYPASS_EN
               state_nxt = zero_c ? ST_DONE : ST_BUSY;
`else
               state_nxt = ST_BUSY;
`endif
            end
         end
         ST_BUSY: if (cnt_q == last_c) state_nxt = ST_SIGN;
         ST_SIGN: state_nxt = ST_DONE;
         ST_DONE: if (i_mul_res_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (i_mul_flush) state_nxt = ST_IDLE;
   end

   // State register with registered handshake flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         o_mul_ready <= 1'b1;
         o_mul_valid <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         o_mul_ready <= (state_nxt == ST_IDLE);
         o_mul_valid <= (state_nxt == ST_DONE);
      end
   end

   // Datapath: capture, shift-add iterations, result register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q        <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         cnt_q        <= '0;
         neg_q        <= 1'b0;
         ctrl_q       <= '0;
         word_q       <= 1'b0;
         tag_q        <= '0;
         o_mul_result <= '0;
         o_mul_tag    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  acc_q    <= '0;
                  mcand_q  <= PW'(mag_a_c);
                  mplier_q <= mag_b_c;
                  cnt_q    <= '0;
                  neg_q    <= sign_a_c ^ sign_b_c;
                  ctrl_q   <= i_mul_control;
                  word_q   <= i_mul_isword;
                  tag_q    <= i_mul_tag;
`ifdef MUL_ZERO_BYPASS_EN
                  if (zero_c) begin
                     o_mul_result <= '0;
                     o_mul_tag    <= i_mul_tag;
                  end
`endif
               end
            end
            ST_BUSY: begin
               acc_q    <= acc_q + addend_c;
               mcand_q  <= mcand_q << RADIX_BITS;
               mplier_q <= mplier_q >> RADIX_BITS;
               cnt_q    <= cnt_q + CNT_W'(1);
            end
            ST_SIGN: begin
               if (!i_mul_flush) begin
                  o_mul_result <= res_sel_c;
                  o_mul_tag    <= tag_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_core_mul_seq.sv
// Self-checking bench for riscv_core_mul_seq: directed vectors plus random
// operations against a 128-bit arithmetic reference model.
module tb_riscv_core_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mul_valid = 1'b0;
   logic        mul_ready;
   logic [63:0] src_a = '0;
   logic [63:0] src_b = '0;
   logic [1:0]  ctrl = '0;
   logic        isword = 1'b0;
   logic [4:0]  tag_in = '0;
   logic        flush = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [63:0] result;
   logic [4:0]  tag_out;

   int total = 0;
   int bad   = 0;

   riscv_core_mul_seq #(.XLEN(64), .RADIX_BITS(2), .TAG_W(5)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_mul_valid(mul_valid), .o_mul_ready(mul_ready),
      .i_mul_srcA(src_a), .i_mul_srcB(src_b),
      .i_mul_control(ctrl), .i_mul_isword(isword), .i_mul_tag(tag_in),
      .i_mul_flush(flush),
      .o_mul_valid(res_valid), .i_mul_res_ready(res_ready),
      .o_mul_result(result), .o_mul_tag(tag_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%016h expected=0x%016h", name, got, exp);
      end
   endtask

   // Reference: exact 128-bit product of the operands extended per op.
   function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] c, input logic w);
      logic [127:0] ea, eb, p;
      if (w) begin
         p = 128'(a[31:0]) * 128'(b[31:0]);
         return {{32{p[31]}}, p[31:0]};
      end
      ea = (c == 2'b11) ? {64'b0, a} : {{64{a[63]}}, a};
      eb = c[1] ? {64'b0, b} : {{64{b[63]}}, b};
      p  = ea * eb;
      return (c == 2'b00) ? p[63:0] : p[127:64];
   endfunction

   function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b, input logic w);
      int n;
      logic z;
      n = w ? 16 : 32;
      z = w ? (a[31:0] == 32'b0 || b[31:0] == 32'b0) : (a == 64'b0 || b == 64'b0);
`ifdef MUL_ZERO_BYPASS_EN
      if (z) return 1;
`else
      if (z) n = n;
`endif
      return n + 2;
   endfunction

   // Offer one operation; returns one step after the accept edge (cycle 1).
   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                        input logic w, input logic [4:0] t);
      check("ready_before_issue", 64'(mul_ready), 64'd1);
      src_a = a; src_b = b; ctrl = c; isword = w; tag_in = t;
      mul_valid = 1'b1;
      @(posedge clk); #1;
      mul_valid = 1'b0;
      src_a = 64'(~a); src_b = 64'($urandom);
   endtask

   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                        input logic w, input logic [4:0] t, input logic [63:0] exp,
                        input int stall);
      int cyc;
      int lat;
      lat = ref_lat(a, b, w);
      issue(a, b, c, w, t);
      cyc = 1;
      while (!res_valid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", 64'(cyc), 64'(lat));
      check("result", result, exp);
      check("tag", 64'(tag_out), 64'(t));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 64'(res_valid), 64'd1);
         check("hold_result", result, exp);
         check("hold_tag", 64'(tag_out), 64'(t));
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("valid_after_take", 64'(res_valid), 64'd0);
      check("ready_after_take", 64'(mul_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] a, b;
      logic [1:0]  c;
      logic        w;
      logic        seen;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(mul_ready), 64'd1);
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_tag", 64'(tag_out), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors
      do_op(-64'sd3, 64'd5, 2'b00, 1'b0, 5'd7, 64'hFFFF_FFFF_FFFF_FFF1, 0);
      do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 5'd1,
            64'h4000_0000_0000_0000, 0);
      do_op('1, '1, 2'b01, 1'b0, 5'd2, 64'h0, 0);
      do_op('1, '1, 2'b10, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      do_op('1, '1, 2'b11, 1'b0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      do_op(64'h1234_5678_7FFF_FFFF, 64'h2, 2'b00, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      do_op(64'h0, 64'h1234, 2'b00, 1'b0, 5'd6, 64'h0, 0);

      // Backpressure: result held 5 cycles in DONE
      do_op(64'd123456789, -64'sd987, 2'b00, 1'b0, 5'd9, 64'(-64'sd121851850743), 5);

      // Flush at cycle 10 of the next op
      issue(64'd11, 64'd13, 2'b00, 1'b0, 5'd10);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_ready", 64'(mul_ready), 64'd1);
      check("flush_valid", 64'(res_valid), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (res_valid) seen = 1'b1;
      end
      check("flush_no_result", 64'(seen), 64'd0);
      do_op(64'd11, 64'd13, 2'b00, 1'b0, 5'd11, 64'd143, 0);

      // Asynchronous reset in the middle of a BUSY operation
      issue(64'hDEAD_BEEF, 64'h1234_5678, 2'b11, 1'b0, 5'd21);
      repeat (19) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ready", 64'(mul_ready), 64'd1);
      check("midrst_valid", 64'(res_valid), 64'd0);
      check("midrst_result", result, 64'd0);
      check("midrst_tag", 64'(tag_out), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(64'hDEAD_BEEF, 64'h1234_5678, 2'b11, 1'b0, 5'd22,
            ref_mul(64'hDEAD_BEEF, 64'h1234_5678, 2'b11, 1'b0), 0);

      // Random operations
      for (int k = 0; k < 40; k++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: a = 64'h8000_0000_0000_0000;
            1: b = '1;
            2: a = 64'h0;
            3: b = 64'h0000_0000_8000_0000;
            default: ;
         endcase
         c = 2'($urandom_range(0, 3));
         w = ($urandom_range(0, 3) == 0);
         do_op(a, b, c, w, 5'($urandom), ref_mul(a, b, c, w), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_core_mul_seq.md
# riscv_core_mul_seq

Iterative, handshaked integer multiplier for the RV64 M-extension execute stage. Accepts one MUL/MULH/MULHSU/MULHU/MULW operation at a time, conditions operands to magnitude form, runs a radix-2^RADIX_BITS shift-add loop, applies the sign correction, and selects the architectural result. Sits between the issue stage and writeback arbitration, replacing the single-cycle multiplier input path with a parametrised multi-cycle unit.

## Interface
- XLEN, 64, operand/result width; must be even.
- RADIX_BITS, 2, multiplier bits consumed per iteration; legal values 1, 2, 4; must divide XLEN/2.
- TAG_W, 5, width of the destination tag carried alongside the operation.

- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_mul_valid  in  1  operation offered.
- o_mul_ready  out  1  unit can accept; high only in IDLE.
- i_mul_srcA  in  XLEN  rs1 value.
- i_mul_srcB  in  XLEN  rs2 value.
- i_mul_control  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- i_mul_isword  in  1  1 = MULW; overrides i_mul_control.
- i_mul_tag  in  TAG_W  destination tag.
- i_mul_flush  in  1  abort any operation in flight.
- o_mul_valid  out  1  result available.
- i_mul_res_ready  in  1  consumer takes result.
- o_mul_result  out  XLEN  result.
- o_mul_tag  out  TAG_W  tag of the result.

## Operation
- States: IDLE, BUSY, SIGN, DONE.
- IDLE: accept when i_mul_valid & o_mul_ready & !i_mul_flush. Capture tag, mode, |srcA|, |srcB| and the negate flag.
  - MUL/MULH: both signed. MULHSU: srcA signed, srcB unsigned. MULHU: both unsigned.
  - MULW: low XLEN/2 bits of each operand, both signed. Upper bits are ignored.
  - Magnitudes are unsigned XLEN bits, so the most-negative value (2^(XLEN-1)) is representable.
  - Negate flag = sign(A) XOR sign(B), over the operands treated as signed only.
- BUSY: each cycle, add multiplicand × next RADIX_BITS multiplier digit into a 2·XLEN accumulator, then shift.
  - Iteration count N = XLEN/RADIX_BITS, or (XLEN/2)/RADIX_BITS for MULW.
  - Counter reaches N-1 → SIGN.
- SIGN: if negate flag set, two's-complement the 2·XLEN product. Then register the selected result and go to DONE.
  - MUL: product[XLEN-1:0].
  - MULH, MULHSU, MULHU: product[2XLEN-1:XLEN].
  - MULW: sign-extend product[XLEN/2-1:0] to XLEN.
- DONE: o_mul_valid=1. o_mul_result and o_mul_tag are held stable until i_mul_res_ready, then → IDLE.
- i_mul_flush in any state → IDLE next cycle. o_mul_valid drops and no result is produced. Flush takes priority over accept and over i_mul_res_ready.

## Timing
- Reset (async assert, sync release): state IDLE, o_mul_ready=1, o_mul_valid=0, o_mul_result=0, o_mul_tag=0, accumulator and counter 0.
- Accept at edge 0. BUSY on cycles 1..N, SIGN on cycle N+1, o_mul_valid on cycle N+2.
  - XLEN=64, RADIX_BITS=2: full ops have valid at cycle 34; MULW has valid at cycle 18.
- o_mul_ready is a registered-state decode: high in IDLE only. No back-to-back accept in DONE; the next accept is earliest the cycle after the result handshake.
- Reset mid-operation: immediate return to the reset values; the operation is lost.

## Configuration
- MUL_ZERO_BYPASS_EN defined: if either captured magnitude is zero at accept, go directly IDLE → DONE with result 0. o_mul_valid on cycle 1.
- MUL_ZERO_BYPASS_EN undefined: zero operands take the full N+2 latency with the same result.

## Test plan
- MUL srcA=-3, srcB=5 → o_mul_result=0xFFFF_FFFF_FFFF_FFF1, o_mul_valid at cycle 34, tag echoed.
- MULH srcA=srcB=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000. MULH srcA=-1, srcB=-1 → 0x0.
- srcA=0xFFFF_FFFF_FFFF_FFFF, srcB=0xFFFF_FFFF_FFFF_FFFF:
  - MULHSU → 0xFFFF_FFFF_FFFF_FFFF.
  - MULHU → 0xFFFF_FFFF_FFFF_FFFE.
- MULW srcA=0x1234_5678_7FFF_FFFF, srcB=0x2 → 0xFFFF_FFFF_FFFF_FFFE, o_mul_valid at cycle 18.
- Backpressure then flush:
  - Hold i_mul_res_ready=0 for 5 cycles in DONE → result and tag stable; on release, o_mul_ready=1 next cycle.
  - Second op flushed at cycle 10 → o_mul_valid never asserts; o_mul_ready=1 at cycle 11; new op accepted and correct.
- srcA=0, srcB=0x1234:
  - With MUL_ZERO_BYPASS_EN → result 0, valid at cycle 1.
  - Without → result 0, valid at cycle 34.
  - Async reset at cycle 20 of a BUSY op → outputs return to reset values immediately.
